// File: rtl/execution_stage_muldiv.sv
// ---------------------------------------------------------------------------
// execution_stage_muldiv
//
// Execute stage with an iterative multiply/divide unit. Non-mul/div
// instructions pass their single-cycle ALU result to the output registers
// in one cycle. Mul/div instructions stall the upstream pipeline while a
// radix-2 shift-add multiplier or a restoring divider runs one bit per
// cycle on operand magnitudes. The sign is fixed up when the result is
// written out.
//
// Ports
//   CLK, RESET_N            clock (rising edge), async active-low reset
//   STALL_EXECUTION_STAGE   downstream stall: hold the output registers
//   CLEAR_EXECUTION_STAGE   synchronous flush, overrides stall
//   VALID_IN, MD_START_IN   instruction present / instruction is mul/div
//   MD_OP_IN                funct3 (MUL..REMU)
//   RS1_DATA, RS2_DATA      operands
//   ALU_RESULT_IN           result for non-mul/div instructions
//   RD_ADDRESS_IN, RD_WRITE_ENABLE_IN   destination register fields
//   STALL_REQUEST           hold upstream stages
//   VALID_OUT, RESULT_OUT, RD_ADDRESS_OUT, RD_WRITE_ENABLE_OUT
//                           registered stage outputs
// ---------------------------------------------------------------------------
module execution_stage_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int MD_OP_WIDTH   = 3
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     STALL_EXECUTION_STAGE,
    input  logic                     CLEAR_EXECUTION_STAGE,
    input  logic                     VALID_IN,
    input  logic                     MD_START_IN,
    input  logic [MD_OP_WIDTH-1:0]   MD_OP_IN,
    input  logic [DATA_WIDTH-1:0]    RS1_DATA,
    input  logic [DATA_WIDTH-1:0]    RS2_DATA,
    input  logic [DATA_WIDTH-1:0]    ALU_RESULT_IN,
    input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_IN,
    input  logic                     RD_WRITE_ENABLE_IN,
    output logic                     STALL_REQUEST,
    output logic                     VALID_OUT,
    output logic [DATA_WIDTH-1:0]    RESULT_OUT,
    output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_OUT,
    output logic                     RD_WRITE_ENABLE_OUT
);

    localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  CNT_START = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};

    // Two's-complement magnitude of a value flagged as negative.
    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic signed [DATA_WIDTH-1:0] value,
        input logic                         is_neg
    );
        logic signed [DATA_WIDTH-1:0] negated;
        negated = -value;
        return is_neg ? negated : value;
    endfunction

    // Sign fix-up and result selection from the finished accumulator.
    // Multiply leaves the full product in acc; divide leaves
    // {remainder, quotient}.
    function automatic logic [DATA_WIDTH-1:0] select_result(
        input logic [2*DATA_WIDTH-1:0] acc_val,
        input logic [2:0]              op_val,
        input logic                    neg_res,
        input logic                    neg_rem
    );
        logic [2*DATA_WIDTH-1:0] prod;
        logic [DATA_WIDTH-1:0]   quo;
        logic [DATA_WIDTH-1:0]   rem;
        prod = neg_res ? -acc_val : acc_val;
        quo  = neg_res ? -acc_val[DATA_WIDTH-1:0] : acc_val[DATA_WIDTH-1:0];
        rem  = neg_rem ? -acc_val[2*DATA_WIDTH-1:DATA_WIDTH]
                       : acc_val[2*DATA_WIDTH-1:DATA_WIDTH];
        if (op_val[2])
            return op_val[1] ? rem : quo;
        else if (op_val[1:0] == 2'd0)
            return prod[DATA_WIDTH-1:0];
        else
            return prod[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    logic [1:0]               state;
    logic [CNT_WIDTH-1:0]     count;
    logic [2*DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]    opb;
    logic [2:0]               op;
    logic                     neg_res;
    logic                     neg_rem;
    logic [REG_ADD_WIDTH-1:0] rd_address_lat;
    logic                     rd_write_enable_lat;

    logic                     vld_p1;
    logic [DATA_WIDTH-1:0]    result_p1;
    logic [REG_ADD_WIDTH-1:0] rd_address_p1;
    logic                     rd_write_enable_p1;

    // Operand decode for an incoming mul/div.
    logic                  in_is_div;
    logic                  in_a_signed;
    logic                  in_b_signed;
    logic                  in_a_neg;
    logic                  in_b_neg;
    logic [DATA_WIDTH-1:0] in_a_abs;
    logic [DATA_WIDTH-1:0] in_b_abs;
    logic                  in_div_zero;
    logic                  in_div_ovf;
    logic                  accept;

    always_comb begin
        in_is_div   = MD_OP_IN[2];
        // DIV/REM have funct3 bit 0 clear; MULH and MULHSU treat RS1 as signed.
        in_a_signed = in_is_div ? ~MD_OP_IN[0]
                                : (MD_OP_IN[1:0] == 2'd1) || (MD_OP_IN[1:0] == 2'd2);
        in_b_signed = in_is_div ? ~MD_OP_IN[0] : (MD_OP_IN[1:0] == 2'd1);
        in_a_neg    = in_a_signed & RS1_DATA[DATA_WIDTH-1];
        in_b_neg    = in_b_signed & RS2_DATA[DATA_WIDTH-1];
        in_a_abs    = magnitude(RS1_DATA, in_a_neg);
        in_b_abs    = magnitude(RS2_DATA, in_b_neg);
        in_div_zero = in_is_div && (RS2_DATA == '0);
        in_div_ovf  = in_is_div && ~MD_OP_IN[0] &&
                      (RS1_DATA == MOST_NEG) && (RS2_DATA == ALL_ONES);
        accept      = (state == ST_IDLE) && VALID_IN && MD_START_IN &&
                      !CLEAR_EXECUTION_STAGE;
    end

    // One iteration of the shift-add multiplier or the restoring divider.
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     rem_shift;
    logic                    rem_ge;
    logic [DATA_WIDTH-1:0]   rem_diff;
    logic [2*DATA_WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    {1'b0, opb & {DATA_WIDTH{acc[0]}}};
        rem_shift = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
        rem_ge    = rem_shift >= {1'b0, opb};
        // Only used when rem_ge, where the true difference is below the divisor.
        rem_diff  = rem_shift[DATA_WIDTH-1:0] - opb;
        if (op[2])
            acc_step = {(rem_ge ? rem_diff : rem_shift[DATA_WIDTH-1:0]),
                        acc[DATA_WIDTH-2:0], rem_ge};
        else
            acc_step = {mul_sum, acc[DATA_WIDTH-1:1]};
    end

    always_comb begin
        STALL_REQUEST = 1'b0;
        case (state)
            ST_IDLE: STALL_REQUEST = VALID_IN && MD_START_IN;
            ST_BUSY: STALL_REQUEST = 1'b1;
            ST_DONE: STALL_REQUEST = STALL_EXECUTION_STAGE;
            default: STALL_REQUEST = 1'b0;
        endcase
        if (!RESET_N || CLEAR_EXECUTION_STAGE)
            STALL_REQUEST = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state               <= ST_IDLE;
            count               <= '0;
            acc                 <= '0;
            opb                 <= '0;
            op                  <= '0;
            neg_res             <= 1'b0;
            neg_rem             <= 1'b0;
            rd_address_lat      <= '0;
            rd_write_enable_lat <= 1'b0;
            vld_p1              <= 1'b0;
            result_p1           <= '0;
            rd_address_p1       <= '0;
            rd_write_enable_p1  <= 1'b0;
        end else if (CLEAR_EXECUTION_STAGE) begin
            state              <= ST_IDLE;
            count              <= '0;
            vld_p1             <= 1'b0;
            result_p1          <= '0;
            rd_address_p1      <= '0;
            rd_write_enable_p1 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op                  <= MD_OP_IN[2:0];
                        rd_address_lat      <= RD_ADDRESS_IN;
                        rd_write_enable_lat <= RD_WRITE_ENABLE_IN;
                        count               <= CNT_START;
                        opb                 <= in_is_div ? in_b_abs : in_a_abs;
                        if (in_div_zero) begin
                            // Remainder half = dividend, quotient half = all ones.
                            acc     <= {RS1_DATA, ALL_ONES};
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= ST_DONE;
                        end else if (in_div_ovf) begin
                            acc     <= {{DATA_WIDTH{1'b0}}, RS1_DATA};
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            // Low half holds the multiplier or the dividend.
                            acc     <= {{DATA_WIDTH{1'b0}}, in_is_div ? in_a_abs : in_b_abs};
                            neg_res <= in_a_neg ^ in_b_neg;
                            neg_rem <= in_a_neg;
                            state   <= ST_BUSY;
                        end
                    end
                    if (!STALL_EXECUTION_STAGE) begin
                        if (VALID_IN && !MD_START_IN) begin
                            vld_p1             <= 1'b1;
                            result_p1          <= ALU_RESULT_IN;
                            rd_address_p1      <= RD_ADDRESS_IN;
                            rd_write_enable_p1 <= RD_WRITE_ENABLE_IN;
                        end else begin
                            vld_p1             <= 1'b0;
                            result_p1          <= '0;
                            rd_address_p1      <= '0;
                            rd_write_enable_p1 <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_step;
                    count <= count - 1'b1;
                    if (count == '0)
                        state <= ST_DONE;
                    if (!STALL_EXECUTION_STAGE) begin
                        vld_p1             <= 1'b0;
                        result_p1          <= '0;
                        rd_address_p1      <= '0;
                        rd_write_enable_p1 <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Held upstream inputs are ignored here so the finished
                    // instruction is not restarted.
                    if (!STALL_EXECUTION_STAGE) begin
                        vld_p1             <= 1'b1;
                        result_p1          <= select_result(acc, op, neg_res, neg_rem);
                        rd_address_p1      <= rd_address_lat;
                        rd_write_enable_p1 <= rd_write_enable_lat;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign VALID_OUT           = vld_p1;
    assign RESULT_OUT          = result_p1;
    assign RD_ADDRESS_OUT      = rd_address_p1;
    assign RD_WRITE_ENABLE_OUT = rd_write_enable_p1;

endmodule

// File: tb/tb_execution_stage_muldiv.sv
// ---------------------------------------------------------------------------
// tb_execution_stage_muldiv
//
// Directed bench for execution_stage_muldiv: ALU pass-through, bubbles,
// multiply and divide variants, division special cases, flush, async reset
// and downstream stall in DONE.
// ---------------------------------------------------------------------------
module tb_execution_stage_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        clear;
    logic        valid_in;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we;
    logic        stall_req;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execution_stage_muldiv #(
        .DATA_WIDTH   (32),
        .REG_ADD_WIDTH(5),
        .MD_OP_WIDTH  (3)
    ) dut (
        .CLK                  (clk),
        .RESET_N              (rst_n),
        .STALL_EXECUTION_STAGE(stall),
        .CLEAR_EXECUTION_STAGE(clear),
        .VALID_IN             (valid_in),
        .MD_START_IN          (md_start),
        .MD_OP_IN             (md_op),
        .RS1_DATA             (rs1),
        .RS2_DATA             (rs2),
        .ALU_RESULT_IN        (alu),
        .RD_ADDRESS_IN        (rd),
        .RD_WRITE_ENABLE_IN   (we),
        .STALL_REQUEST        (stall_req),
        .VALID_OUT            (valid_out),
        .RESULT_OUT           (result),
        .RD_ADDRESS_OUT       (rd_out),
        .RD_WRITE_ENABLE_OUT  (we_out)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        valid_in = 1'b0;
        md_start = 1'b0;
        md_op    = 3'd0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        alu      = 32'd0;
        rd       = 5'd0;
        we       = 1'b0;
    endtask

    task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1;
        md_start = 1'b1;
        md_op    = op;
        rs1      = a;
        rs2      = b;
        alu      = 32'd0;
        rd       = 5'd9;
        we       = 1'b1;
    endtask

    task automatic drive_alu(input logic [31:0] value, input logic [4:0] addr);
        valid_in = 1'b1;
        md_start = 1'b0;
        md_op    = 3'd0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        alu      = value;
        rd       = addr;
        we       = 1'b1;
    endtask

    // Issue one mul/div and wait for VALID_OUT; edges = -1 on timeout.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int edges, output int stalls);
        bit got;
        got    = 1'b0;
        res    = 32'd0;
        edges  = 0;
        stalls = 0;
        @(negedge clk);
        drive_md(op, a, b);
        #1;
        while (!got && edges < 100) begin
            if (stall_req) stalls++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (valid_out) begin
                got = 1'b1;
                res = result;
            end
        end
        drive_idle();
        if (!got) edges = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        clear = 1'b0;
        drive_md(3'd0, 32'd7, 32'd3);
        #12;
        n_checks++;
        if (stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall_req: got %b expected 0", stall_req);
        end
        n_checks++;
        if ({valid_out, result, rd_out, we_out} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%h/%h/%b expected all zero",
                     valid_out, result, rd_out, we_out);
        end
        // Release reset with an ALU op waiting; the first edge must take it.
        @(negedge clk);
        drive_alu(32'h0000CAFE, 5'd3);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || result !== 32'h0000CAFE || rd_out !== 5'd3) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %b/%h/%h expected 1/0000cafe/03",
                     valid_out, result, rd_out);
        end
        drive_idle();
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive_alu(32'hDEADBEEF, 5'd17);
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || result !== 32'hDEADBEEF || rd_out !== 5'd17 || we_out !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_pass: got %b/%h/%h/%b expected 1/deadbeef/11/1",
                     valid_out, result, rd_out, we_out);
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0 || result !== 32'd0 || we_out !== 1'b0 || rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL bubble: got %b/%h/%h/%b expected 0/00000000/00/0",
                     valid_out, result, rd_out, we_out);
        end
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int edges;
        int stalls;
        run_md(3'd0, 32'd7, 32'hFFFFFFFD, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFEB) begin
            n_fail++;
            $display("FAIL mul_result: got %h expected ffffffeb", res);
        end
        n_checks++;
        if (edges !== 34) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d edges expected 34", edges);
        end
        n_checks++;
        if (stalls !== 33) begin
            n_fail++;
            $display("FAIL mul_stall_cycles: got %0d expected 33", stalls);
        end
        n_checks++;
        if (rd_out !== 5'd9 || we_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_rd_fields: got %h/%b expected 09/1", rd_out, we_out);
        end
    endtask

    task automatic test_mul_high();
        logic [31:0] res;
        int edges;
        int stalls;
        run_md(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL mulhu: got %h expected fffffffe", res);
        end
        run_md(3'd2, 32'hFFFFFFFF, 32'd2, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL mulhsu: got %h expected ffffffff", res);
        end
        // (-1) * (-1) = 1, high half 0
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, res, edges, stalls);
        n_checks++;
        if (res !== 32'h00000000) begin
            n_fail++;
            $display("FAIL mulh: got %h expected 00000000", res);
        end
    endtask

    task automatic test_div();
        logic [31:0] res;
        int edges;
        int stalls;
        run_md(3'd4, 32'hFFFFFFF9, 32'd2, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_neg: got %h expected fffffffd", res);
        end
        n_checks++;
        if (edges !== 34) begin
            n_fail++;
            $display("FAIL div_latency: got %0d edges expected 34", edges);
        end
        run_md(3'd6, 32'hFFFFFFF9, 32'd2, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL rem_neg: got %h expected ffffffff", res);
        end
        run_md(3'd5, 32'd100, 32'd7, res, edges, stalls);
        n_checks++;
        if (res !== 32'd14) begin
            n_fail++;
            $display("FAIL divu: got %h expected 0000000e", res);
        end
        run_md(3'd7, 32'd100, 32'd7, res, edges, stalls);
        n_checks++;
        if (res !== 32'd2) begin
            n_fail++;
            $display("FAIL remu: got %h expected 00000002", res);
        end
    endtask

    task automatic test_div_special();
        logic [31:0] res;
        int edges;
        int stalls;
        run_md(3'd5, 32'd5, 32'd0, res, edges, stalls);
        n_checks++;
        if (res !== 32'hFFFFFFFF || edges !== 2) begin
            n_fail++;
            $display("FAIL divu_by_zero: got %h in %0d edges expected ffffffff in 2", res, edges);
        end
        n_checks++;
        if (stalls !== 1) begin
            n_fail++;
            $display("FAIL special_stall_cycles: got %0d expected 1", stalls);
        end
        run_md(3'd6, 32'd5, 32'd0, res, edges, stalls);
        n_checks++;
        if (res !== 32'd5 || edges !== 2) begin
            n_fail++;
            $display("FAIL rem_by_zero: got %h in %0d edges expected 00000005 in 2", res, edges);
        end
        run_md(3'd4, 32'h80000000, 32'hFFFFFFFF, res, edges, stalls);
        n_checks++;
        if (res !== 32'h80000000 || edges !== 2) begin
            n_fail++;
            $display("FAIL div_overflow: got %h in %0d edges expected 80000000 in 2", res, edges);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        drive_md(3'd0, 32'd7, 32'd3);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++;
        if (stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_stall_req: got %b expected 0", stall_req);
        end
        @(negedge clk);
        clear = 1'b0;
        drive_alu(32'h00001234, 5'd4);
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: got valid %b stall_req %b expected 0/0", valid_out, stall_req);
        end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || result !== 32'h00001234 || rd_out !== 5'd4) begin
            n_fail++;
            $display("FAIL clear_then_add: got %b/%h/%h expected 1/00001234/04",
                     valid_out, result, rd_out);
        end
        drive_idle();
        // The discarded multiply must never surface.
        repeat (40) @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_discard: got valid %b result %h expected 0", valid_out, result);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_alu(32'h0000ABCD, 5'd2);
        @(negedge clk);
        stall = 1'b1;
        drive_md(3'd0, 32'd7, 32'd3);
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || result !== 32'h0000ABCD || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold_busy: got %b/%h/%b expected 1/0000abcd/1",
                     valid_out, result, stall_req);
        end
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, result, rd_out, we_out, stall_req} !== 40'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%h/%h/%b/%b expected all zero",
                     valid_out, result, rd_out, we_out, stall_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_done_stall();
        @(negedge clk);
        drive_alu(32'h00000055, 5'd1);
        @(negedge clk);
        stall = 1'b1;
        drive_md(3'd5, 32'd100, 32'd7);
        repeat (33) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (stall_req !== 1'b1 || result !== 32'h00000055 || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL done_stall_hold[%0d]: got stall_req %b result %h valid %b expected 1/00000055/1",
                         k, stall_req, result, valid_out);
            end
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL done_release_stall_req: got %b expected 0", stall_req);
        end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || result !== 32'd14 || rd_out !== 5'd9) begin
            n_fail++;
            $display("FAIL done_release_load: got %b/%h/%h expected 1/0000000e/09",
                     valid_out, result, rd_out);
        end
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_mul_high();
        test_div();
        test_div_special();
        test_clear();
        test_async_reset();
        test_done_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
